// File: rtl/poisson_spike_encoder.sv
// rtl/poisson_spike_encoder.sv - Stochastic rate-to-spike encoder with LFSR seeding
//
// Holds one firing-rate word per neuron. Each tick scans every neuron once,
// one per cycle. A neuron fires when its rate is strictly greater than the
// current LFSR sample. Firing addresses leave over a valid/ready handshake.
// This block also drives the LFSR seed load.
//
// Optional build macro: REFRACTORY_EN
//   When defined, a neuron that spiked in one tick is forced silent in the next.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   cfg_we/cfg_addr/cfg_rate    rate table write port (any state)
//   seed_load/seed_value        reseed request, honoured only in IDLE without tick
//   lfsr_seed_dv/lfsr_seed_data seed strobe/data toward the LFSR
//   lfsr_data                   LFSR sample consumed every cycle
//   tick                        timestep start pulse
//   busy                        scan in progress
//   spike_valid/spike_ready/spike_addr  spike address stream
//   spike_cnt                   spikes emitted in the current/last tick
//   tick_done                   one-cycle pulse at end of scan
//   tick_overrun                one-cycle pulse when a tick is dropped
module poisson_spike_encoder #(
    parameter int NEURON_NUM = 256,
    parameter int ADDR_W     = 8,
    parameter int RATE_W     = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [RATE_W-1:0] cfg_rate,
    input  logic              seed_load,
    input  logic [RATE_W-1:0] seed_value,
    output logic              lfsr_seed_dv,
    output logic [RATE_W-1:0] lfsr_seed_data,
    input  logic [RATE_W-1:0] lfsr_data,
    input  logic              tick,
    output logic              busy,
    output logic              spike_valid,
    input  logic              spike_ready,
    output logic [ADDR_W-1:0] spike_addr,
    output logic [ADDR_W:0]   spike_cnt,
    output logic              tick_done,
    output logic              tick_overrun
);

    localparam int                IDX_W    = (NEURON_NUM > 1) ? $clog2(NEURON_NUM) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NEURON_NUM - 1);
    localparam logic [ADDR_W:0]   NUM_EXT  = (ADDR_W + 1)'(NEURON_NUM);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_EMIT,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] idx;
    logic [RATE_W-1:0] rate_tbl [NEURON_NUM];
    logic [RATE_W-1:0] cur_rate;
    logic              fire;
    logic              last;
    logic              cfg_hit;
    logic              seed_take;

    // Combinational read: a same-cycle write to idx is seen only next cycle.
    assign cur_rate  = rate_tbl[idx[IDX_W-1:0]];
    assign last      = (idx == LAST_IDX);
    assign cfg_hit   = ({1'b0, cfg_addr} < NUM_EXT);
    assign seed_take = (state == S_IDLE) && seed_load && !tick;

`ifdef REFRACTORY_EN
    logic [NEURON_NUM-1:0] refr;
    assign fire = (cur_rate > lfsr_data) && !refr[idx[IDX_W-1:0]];
`else
    assign fire = (cur_rate > lfsr_data);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        busy        = 1'b0;
        spike_valid = 1'b0;
        tick_done   = 1'b0;
        case (state)
            S_IDLE: begin
                if (tick) state_nx = S_SCAN;
            end
            S_SCAN: begin
                busy = 1'b1;
                if (fire)      state_nx = S_EMIT;
                else if (last) state_nx = S_DONE;
            end
            S_EMIT: begin
                busy        = 1'b1;
                spike_valid = 1'b1;
                if (spike_ready) state_nx = last ? S_DONE : S_SCAN;
            end
            S_DONE: begin
                tick_done = 1'b1;
                state_nx  = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx            <= '0;
            spike_addr     <= '0;
            spike_cnt      <= '0;
            lfsr_seed_dv   <= 1'b0;
            lfsr_seed_data <= '0;
            tick_overrun   <= 1'b0;
        end else begin
            lfsr_seed_dv <= seed_take;
            if (seed_take) lfsr_seed_data <= seed_value;
            // Any tick not taken from IDLE (SCAN, EMIT or DONE) is dropped.
            tick_overrun <= tick && (state != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (tick) begin
                        idx       <= '0;
                        spike_cnt <= '0;
                    end
                end
                S_SCAN: begin
                    if (fire)       spike_addr <= idx;
                    else if (!last) idx        <= idx + 1'b1;
                end
                S_EMIT: begin
                    if (spike_ready) begin
                        spike_cnt <= spike_cnt + 1'b1;
                        if (!last) idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NEURON_NUM; i++) rate_tbl[i] <= '0;
        end else if (cfg_we && cfg_hit) begin
            rate_tbl[cfg_addr[IDX_W-1:0]] <= cfg_rate;
        end
    end

`ifdef REFRACTORY_EN
    // Evaluation clears the flag; an accepted spike sets it for the next tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refr <= '0;
        end else if (state == S_SCAN) begin
            refr[idx[IDX_W-1:0]] <= 1'b0;
        end else if (state == S_EMIT && spike_ready) begin
            refr[idx[IDX_W-1:0]] <= 1'b1;
        end
    end
`endif

endmodule
